// File: rtl/shift_req_arbiter.sv
// Two-requester round-robin arbiter sharing one 8-bit rotate datapath, with a
// one-entry registered output stage. Define SHIFT_ARB_STATS_EN for per-requester grant counters.
module shift_req_arbiter #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          req0_valid,
  input  logic [W-1:0]  req0_a,
  input  logic [AW-1:0] req0_amt,
  input  logic          req0_dir,
  output logic          req0_ready,

  input  logic          req1_valid,
  input  logic [W-1:0]  req1_a,
  input  logic [AW-1:0] req1_amt,
  input  logic          req1_dir,
  output logic          req1_ready,

  output logic          rsp_valid,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_id,
  input  logic          rsp_ready
`ifdef SHIFT_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [7:0]    grant_cnt0,
  output logic [7:0]    grant_cnt1
`endif
);

  logic          rsp_valid_q;
  logic [W-1:0]  rsp_data_q;
  logic          rsp_id_q;
  logic          last_grant_q;

  logic          can_accept;
  logic          grant0;
  logic          grant1;

  logic [W-1:0]  sel_a;
  logic [AW-1:0] sel_amt;
  logic          sel_dir;
  logic [W-1:0]  rot_s1;
  logic [W-1:0]  rot_s2;
  logic [W-1:0]  rot_y;

  // Grants depend only on valids, rsp_ready and state; payloads never reach the readies.
  always_comb begin
    can_accept = !rsp_valid_q | rsp_ready;
    grant0     = can_accept & !reset & req0_valid & (!req1_valid | last_grant_q);
    grant1     = can_accept & !reset & req1_valid & (!req0_valid | !last_grant_q);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_a   = grant1 ? req1_a   : req0_a;
    sel_amt = grant1 ? req1_amt : req0_amt;
    sel_dir = grant1 ? req1_dir : req0_dir;
  end

  // Three-stage log rotator; a rotate by 4 is the same in both directions.
  always_comb begin
    if (sel_amt[0]) begin
      rot_s1 = sel_dir ? {sel_a[0], sel_a[7:1]} : {sel_a[6:0], sel_a[7]};
    end else begin
      rot_s1 = sel_a;
    end
    if (sel_amt[1]) begin
      rot_s2 = sel_dir ? {rot_s1[1:0], rot_s1[7:2]} : {rot_s1[5:0], rot_s1[7:6]};
    end else begin
      rot_s2 = rot_s1;
    end
    rot_y = sel_amt[2] ? {rot_s2[3:0], rot_s2[7:4]} : rot_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (grant0 || grant1) begin
      rsp_valid_q  <= 1'b1;
      rsp_data_q   <= rot_y;
      rsp_id_q     <= grant1;
      last_grant_q <= grant1;
    end else if (rsp_ready) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef SHIFT_ARB_STATS_EN
  logic [7:0] grant_cnt0_q;
  logic [7:0] grant_cnt1_q;

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (grant0 && grant_cnt0_q != 8'hFF) grant_cnt0_q <= grant_cnt0_q + 8'd1;
      if (grant1 && grant_cnt1_q != 8'hFF) grant_cnt1_q <= grant_cnt1_q + 8'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
